conv_window_ctrl: RTL and testbench

- Sequencer for the 3x3 convolution line-buffer chain: two cascaded 640-pixel row buffers plus the 3x3 tap register array.
- Accepts the per-pixel valid strobe from the grayscale stage and gates the row-buffer and tap-shift enables.
- Tracks column/row position and flags when the 3x3 window is complete and fully inside the image.
- Supplies window-centre coordinates and frame start/end status to the filter output stage.

---
 rtl/conv_window_ctrl_if.sv | 48 ++++
 rtl/conv_window_ctrl.sv | 173 +++++++++++++++++
 tb/tb_conv_window_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/conv_window_ctrl_if.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl_if
//   Pixel-stream handshake and window-status bundle between the grayscale
//   stage, the 3x3 line-buffer sequencer and the filter output stage.
//
//   Signals
//     frame_start  upstream -> ctrl   single-cycle start-of-frame pulse
//     pix_valid    upstream -> ctrl   pixel present this cycle
//     rowbuf_en    ctrl -> buffers    shift enable for row buffers + taps
//     col, row     ctrl -> out        position of the pixel being accepted
//     win_valid    ctrl -> out        3x3 window complete and inside image
//     out_col/row  ctrl -> out        window-centre coordinates
//     frame_done   ctrl -> out        pulse after the last pixel of a frame
//     frame_err    ctrl -> out        pulse after a mid-frame frame_start
//     busy         ctrl -> out        sequencer not idle
//
//   Modports
//     master : pixel source / observer side
//     slave  : the conv_window_ctrl sequencer
// ---------------------------------------------------------------------------
interface conv_window_ctrl_if #(
  parameter int COL_W = 10,
  parameter int ROW_W = 9
);
  logic             frame_start;
  logic             pix_valid;
  logic             rowbuf_en;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             win_valid;
  logic [COL_W-1:0] out_col;
  logic [ROW_W-1:0] out_row;
  logic             frame_done;
  logic             frame_err;
  logic             busy;

  modport master (
    output frame_start, pix_valid,
    input  rowbuf_en, col, row, win_valid, out_col, out_row,
           frame_done, frame_err, busy
  );

  modport slave (
    input  frame_start, pix_valid,
    output rowbuf_en, col, row, win_valid, out_col, out_row,
           frame_done, frame_err, busy
  );
endinterface

// File: rtl/conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl
//   Sequencer for the 3x3 convolution line-buffer chain (two cascaded
//   IMG_W-deep row buffers plus the 3x3 tap array). Gates the shift enable
//   with the incoming pixel strobe, tracks the column/row of each accepted
//   pixel and reports, one cycle later, whether the window centred on
//   (row-1, col-1) is complete and fully inside the image.
//
//   Ports
//     clk    : clock
//     rst_n  : asynchronous active-low reset
//     bus    : conv_window_ctrl_if.slave
//              in  : frame_start, pix_valid
//              out : rowbuf_en (combinational), col, row, win_valid,
//                    out_col, out_row, frame_done, frame_err, busy
//
//   States: IDLE -> PRIME (first two rows) -> STREAM -> DONE -> IDLE/PRIME
// ---------------------------------------------------------------------------
module conv_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int COL_W = 10,
  parameter int ROW_W = 9
) (
  input  logic               clk,
  input  logic               rst_n,
  conv_window_ctrl_if.slave  bus
);

  // Elaboration-time sanity on the geometry.
  generate
    if (IMG_W < 3 || IMG_H < 3) begin : g_bad_size
      $error("conv_window_ctrl: IMG_W and IMG_H must both be at least 3");
    end
    if ((1 << COL_W) < IMG_W || (1 << ROW_W) < IMG_H) begin : g_bad_width
      $error("conv_window_ctrl: COL_W/ROW_W too narrow for IMG_W/IMG_H");
    end
  endgenerate

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t           state_reg, state_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;
  logic             win_valid_reg;
  logic [COL_W-1:0] out_col_reg;
  logic [ROW_W-1:0] out_row_reg;
  logic             frame_err_reg;

  logic             in_frame;
  logic             accept;
  logic [COL_W-1:0] acc_col;
  logic [ROW_W-1:0] acc_row;
  logic             last_col;
  logic             last_row;

  // A frame_start restarts the frame in the same cycle, so a pixel arriving
  // alongside it is taken as (0,0) of the new frame whatever the state.
  always_comb begin
    in_frame = (state_reg == PRIME) || (state_reg == STREAM);
    accept   = bus.pix_valid && (in_frame || bus.frame_start);
    acc_col  = bus.frame_start ? '0 : col_reg;
    acc_row  = bus.frame_start ? '0 : row_reg;
    last_col = (acc_col == COL_LAST);
    last_row = (acc_row == ROW_LAST);
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    if (bus.frame_start) begin
      state_next = PRIME;
    end else begin
      case (state_reg)
        PRIME: begin
          // Two full rows are in the buffers once (1, IMG_W-1) is taken.
          if (accept && last_col && acc_row == ROW_W'(1)) begin
            state_next = STREAM;
          end
        end
        STREAM: begin
          if (accept && last_col && last_row) begin
            state_next = DONE;
          end
        end
        DONE:    state_next = IDLE;
        default: state_next = state_reg;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.rowbuf_en  = accept;
    bus.busy       = (state_reg != IDLE);
    bus.frame_done = (state_reg == DONE);
  end

  // ---------------- position counters ----------------
  always_comb begin
    col_next = col_reg;
    row_next = row_reg;
    if (bus.frame_start) begin
      col_next = '0;
      row_next = '0;
    end
    if (accept) begin
      if (last_col) begin
        col_next = '0;
        row_next = last_row ? '0 : acc_row + ROW_W'(1);
      end else begin
        col_next = acc_col + COL_W'(1);
        row_next = acc_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_reg <= '0;
      row_reg <= '0;
    end else begin
      col_reg <= col_next;
      row_reg <= row_next;
    end
  end

  // ---------------- window status ----------------
  // Registered so it lines up with the row-buffer read data. The centre is
  // one row up and one column left of the newest pixel; any window whose
  // newest pixel sits in row/col 0 or 1 would overhang the image edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_valid_reg <= 1'b0;
      out_col_reg   <= '0;
      out_row_reg   <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      win_valid_reg <= accept && (acc_row >= ROW_W'(2)) && (acc_col >= COL_W'(2));
      if (accept) begin
        out_col_reg <= acc_col - COL_W'(1);
        out_row_reg <= acc_row - ROW_W'(1);
      end
      // Restart from DONE is a legal back-to-back frame, not an error.
      frame_err_reg <= bus.frame_start && in_frame;
    end
  end

  assign bus.col       = col_reg;
  assign bus.row       = row_reg;
  assign bus.win_valid = win_valid_reg;
  assign bus.out_col   = out_col_reg;
  assign bus.out_row   = out_row_reg;
  assign bus.frame_err = frame_err_reg;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_window_ctrl
//   Self-checking bench for conv_window_ctrl on an 8x6 image. A reference
//   model tracks the frame as a linear count of accepted pixels and derives
//   every expected output from that count.
// ---------------------------------------------------------------------------
module tb_conv_window_ctrl;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int WH = W * H;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  conv_window_ctrl_if #(.COL_W(3), .ROW_W(3)) bus ();

  conv_window_ctrl #(.IMG_W(W), .IMG_H(H), .COL_W(3), .ROW_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  int       idx;        // pixels accepted in the current frame
  bit       in_frame;   // a frame is being received
  bit       done_now;   // the frame finished on the previous edge
  bit       m_win;
  bit       m_err;
  int       m_or, m_oc;
  bit       pend, pfs, ppv;

  bit       exp_rowbuf, exp_busy, exp_done, exp_err, exp_win;
  logic [2:0] exp_col, exp_row, exp_oc, exp_or;

  task automatic model_clear();
    idx = 0; in_frame = 0; done_now = 0;
    m_win = 0; m_err = 0; m_or = 0; m_oc = 0; pend = 0;
  endtask

  task automatic model_edge(input bit fs, input bit pv);
    bit acc;
    int r, c;
    bit new_done;
    acc = pv && (in_frame || fs);
    r = fs ? 0 : (idx % WH) / W;
    c = fs ? 0 : (idx % WH) % W;
    m_win = acc && r >= 2 && c >= 2;
    if (acc) begin
      m_or = r - 1;
      m_oc = c - 1;
    end
    m_err = fs && in_frame;
    new_done = 0;
    if (fs) begin
      in_frame = 1;
      idx = acc ? 1 : 0;
    end else if (acc) begin
      idx++;
      if (idx == WH) begin
        in_frame = 0;
        new_done = 1;
      end
    end
    done_now = new_done;
  endtask

  // Drive one cycle of stimulus at the falling edge; expected values for
  // this cycle are left in exp_* and outputs are settled on return.
  task automatic tick(input bit fs, input bit pv);
    @(negedge clk);
    if (pend) model_edge(pfs, ppv);
    bus.frame_start = fs;
    bus.pix_valid   = pv;
    exp_rowbuf = pv && (in_frame || fs);
    exp_busy   = in_frame || done_now;
    exp_done   = done_now;
    exp_err    = m_err;
    exp_win    = m_win;
    exp_or     = 3'(m_or);
    exp_oc     = 3'(m_oc);
    exp_col    = 3'((idx % WH) % W);
    exp_row    = 3'((idx % WH) / W);
    pfs = fs; ppv = pv; pend = 1;
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b1;
    model_clear();
    #1;
    total++;
    if ({bus.rowbuf_en, bus.busy, bus.win_valid, bus.frame_done, bus.frame_err,
         bus.col, bus.row, bus.out_col, bus.out_row} !== 17'd0) begin
      bad++;
      $display("FAIL reset_vals: got %b want all zero",
               {bus.rowbuf_en, bus.busy, bus.win_valid, bus.frame_done, bus.frame_err,
                bus.col, bus.row, bus.out_col, bus.out_row});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick(1'b0, 1'b1);
      total++;
      if ({bus.rowbuf_en, bus.busy, bus.win_valid, bus.col, bus.row} !== 9'd0) begin
        bad++;
        $display("FAIL idle_ignore: cyc %0d got en/busy/win/col/row=%b want 0",
                 i, {bus.rowbuf_en, bus.busy, bus.win_valid, bus.col, bus.row});
      end
    end
    $display("reset/idle: done");
  endtask

  task automatic test_continuous();
    int wins = 0, dones = 0;
    logic [2:0] first_r = 0, first_c = 0, last_r = 0, last_c = 0;
    for (int i = 0; i < WH + 4; i++) begin
      tick(i == 0, i >= 1 && i <= WH);
      total++;
      if ({bus.rowbuf_en, bus.busy, bus.frame_done} !== {exp_rowbuf, exp_busy, exp_done}) begin
        bad++;
        $display("FAIL cont_ctrl: cyc %0d got en/busy/done=%b want %b", i,
                 {bus.rowbuf_en, bus.busy, bus.frame_done}, {exp_rowbuf, exp_busy, exp_done});
      end
      total++;
      if (bus.win_valid !== exp_win ||
          (exp_win && {bus.out_row, bus.out_col} !== {exp_or, exp_oc})) begin
        bad++;
        $display("FAIL cont_win: cyc %0d got v=%b (%0d,%0d) want v=%b (%0d,%0d)", i,
                 bus.win_valid, bus.out_row, bus.out_col, exp_win, exp_or, exp_oc);
      end
      if (bus.win_valid === 1'b1) begin
        if (wins == 0) begin first_r = bus.out_row; first_c = bus.out_col; end
        last_r = bus.out_row; last_c = bus.out_col;
        wins++;
      end
      if (bus.frame_done === 1'b1) dones++;
    end
    total++;
    if (wins != 24 || dones != 1) begin
      bad++;
      $display("FAIL cont_count: got wins=%0d dones=%0d want 24 1", wins, dones);
    end
    total++;
    if ({first_r, first_c, last_r, last_c} !== {3'd1, 3'd1, 3'd4, 3'd6}) begin
      bad++;
      $display("FAIL cont_ends: got first (%0d,%0d) last (%0d,%0d) want (1,1) (4,6)",
               first_r, first_c, last_r, last_c);
    end
    $display("continuous: wins=%0d dones=%0d", wins, dones);
  endtask

  task automatic test_gapped();
    int wins = 0, accepted = 0, cyc = 0;
    tick(1'b1, 1'b0);
    while (accepted < WH && cyc < 1000) begin
      bit pv;
      pv = (cyc % 2 == 0) || ($urandom_range(0, 3) == 0);
      if (cyc % 2 == 1 && $urandom_range(0, 3) == 0) pv = 1'b0;
      tick(1'b0, pv);
      if (exp_rowbuf) accepted++;
      total++;
      if ({bus.rowbuf_en, bus.col, bus.row} !== {exp_rowbuf, exp_col, exp_row}) begin
        bad++;
        $display("FAIL gap_pos: cyc %0d got en=%b (%0d,%0d) want en=%b (%0d,%0d)", cyc,
                 bus.rowbuf_en, bus.row, bus.col, exp_rowbuf, exp_row, exp_col);
      end
      total++;
      if (bus.win_valid !== exp_win ||
          (exp_win && {bus.out_row, bus.out_col} !== {exp_or, exp_oc})) begin
        bad++;
        $display("FAIL gap_win: cyc %0d got v=%b (%0d,%0d) want v=%b (%0d,%0d)", cyc,
                 bus.win_valid, bus.out_row, bus.out_col, exp_win, exp_or, exp_oc);
      end
      if (bus.win_valid === 1'b1) wins++;
      cyc++;
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      if (bus.win_valid === 1'b1) wins++;
      total++;
      if (bus.frame_done !== exp_done) begin
        bad++;
        $display("FAIL gap_done: got %b want %b", bus.frame_done, exp_done);
      end
    end
    total++;
    if (wins != 24 || accepted != WH) begin
      bad++;
      $display("FAIL gap_count: got wins=%0d accepts=%0d want 24 %0d", wins, accepted, WH);
    end
    $display("gapped: wins=%0d cycles=%0d", wins, cyc);
  endtask

  task automatic test_midframe();
    int errs = 0, wins_after = 0;
    tick(1'b1, 1'b0);
    for (int i = 0; i < 19; i++) tick(1'b0, 1'b1);
    tick(1'b1, 1'b1);  // 20th pixel arrives with a new frame_start
    total++;
    if (bus.rowbuf_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_accept: got rowbuf_en=%b want 1", bus.rowbuf_en);
    end
    for (int i = 0; i < WH + 2; i++) begin
      tick(1'b0, i < WH - 1);
      if (bus.frame_err === 1'b1) errs++;
      if (bus.win_valid === 1'b1) wins_after++;
      total++;
      if ({bus.frame_err, bus.busy, bus.col, bus.row} !== {exp_err, exp_busy, exp_col, exp_row}) begin
        bad++;
        $display("FAIL mid_state: cyc %0d got err=%b busy=%b (%0d,%0d) want err=%b busy=%b (%0d,%0d)",
                 i, bus.frame_err, bus.busy, bus.row, bus.col, exp_err, exp_busy, exp_row, exp_col);
      end
      total++;
      if (bus.win_valid !== exp_win ||
          (exp_win && {bus.out_row, bus.out_col} !== {exp_or, exp_oc})) begin
        bad++;
        $display("FAIL mid_win: cyc %0d got v=%b (%0d,%0d) want v=%b (%0d,%0d)", i,
                 bus.win_valid, bus.out_row, bus.out_col, exp_win, exp_or, exp_oc);
      end
    end
    total++;
    if (errs != 1 || wins_after != 24) begin
      bad++;
      $display("FAIL mid_count: got errs=%0d wins=%0d want 1 24", errs, wins_after);
    end
    $display("midframe: errs=%0d wins=%0d", errs, wins_after);
  endtask

  task automatic test_back_to_back();
    int wins = 0, dones = 0, errs = 0;
    tick(1'b1, 1'b0);
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < WH; i++) begin
        tick(1'b0, 1'b1);
        if (bus.win_valid === 1'b1) wins++;
        if (bus.frame_done === 1'b1) dones++;
        if (bus.frame_err === 1'b1) errs++;
      end
      tick(f == 0, 1'b0);  // DONE cycle; restart here on the first pass
      total++;
      if (bus.frame_done !== 1'b1 || bus.frame_done !== exp_done) begin
        bad++;
        $display("FAIL b2b_done: frame %0d got %b want 1", f, bus.frame_done);
      end
      if (bus.win_valid === 1'b1) wins++;
      if (bus.frame_done === 1'b1) dones++;
      if (bus.frame_err === 1'b1) errs++;
    end
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      if (bus.frame_err === 1'b1) errs++;
      if (bus.frame_done === 1'b1) dones++;
      total++;
      if (bus.busy !== exp_busy) begin
        bad++;
        $display("FAIL b2b_busy: got %b want %b", bus.busy, exp_busy);
      end
    end
    total++;
    if (wins != 48 || dones != 2 || errs != 0) begin
      bad++;
      $display("FAIL b2b_count: got wins=%0d dones=%0d errs=%0d want 48 2 0", wins, dones, errs);
    end
    $display("back_to_back: wins=%0d dones=%0d errs=%0d", wins, dones, errs);
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      tick($urandom_range(0, 79) == 0, $urandom_range(0, 3) != 0);
      total++;
      if ({bus.rowbuf_en, bus.busy, bus.frame_done, bus.frame_err, bus.col, bus.row} !==
          {exp_rowbuf, exp_busy, exp_done, exp_err, exp_col, exp_row}) begin
        bad++;
        $display("FAIL rand_ctrl: cyc %0d got %b want %b", i,
                 {bus.rowbuf_en, bus.busy, bus.frame_done, bus.frame_err, bus.col, bus.row},
                 {exp_rowbuf, exp_busy, exp_done, exp_err, exp_col, exp_row});
      end
      total++;
      if (bus.win_valid !== exp_win ||
          (exp_win && {bus.out_row, bus.out_col} !== {exp_or, exp_oc})) begin
        bad++;
        $display("FAIL rand_win: cyc %0d got v=%b (%0d,%0d) want v=%b (%0d,%0d)", i,
                 bus.win_valid, bus.out_row, bus.out_col, exp_win, exp_or, exp_oc);
      end
    end
    $display("random: 600 cycles");
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.pix_valid   = 1'b0;
    model_clear();
    test_reset();
    test_continuous();
    test_gapped();
    test_midframe();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
